// File: rtl/apb_csr_master.sv
// APB requester: turns single valid/ready read/write commands into one APB
// SETUP+ACCESS transfer each and reports completion on a one-cycle response strobe.
module apb_csr_master #(
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   input  logic              i_cmd_write,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_wdata,
   output logic              o_cmd_ready,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_busy,
   output logic              o_psel,
   output logic              o_penable,
   output logic              o_pwrite,
   output logic [ADDR_W-1:0] o_paddr,
   output logic [DATA_W-1:0] o_pwdata,
   input  logic [DATA_W-1:0] i_prdata,
   input  logic              i_pready,
   input  logic              i_pslverr
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic               busy_q, busy_d;
   logic               psel_q, psel_d;
   logic               penable_q, penable_d;
   logic               pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]  paddr_q, paddr_d;
   logic [DATA_W-1:0]  pwdata_q, pwdata_d;
   logic               accept;
   logic               timeout_hit;

   assign accept  = (state_q == ST_IDLE) && i_cmd_valid && cmd_ready_q;
   assign cnt_inc = cnt_q + 1'b1;
   // Abort fires on the edge that would bring the PREADY-low count up to the limit.
   assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q == ST_ACCESS) && !i_pready &&
                        (cnt_inc == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (i_pready || timeout_hit) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered, so their next values follow the next state.
   always_comb begin
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      psel_d      = (state_d != ST_IDLE);
      penable_d   = (state_d == ST_ACCESS);
      busy_d      = (state_d != ST_IDLE);
      cmd_ready_d = (state_d == ST_IDLE);

      if (accept) begin
         pwrite_d = i_cmd_write;
         paddr_d  = i_cmd_addr;
         pwdata_d = i_cmd_wdata;
         cnt_d    = '0;
      end

      if (state_q == ST_ACCESS) begin
         if (i_pready) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = i_pslverr;
            rsp_rdata_d = pwrite_q ? '0 : i_prdata;
         end else begin
            cnt_d = cnt_inc;
            if (timeout_hit) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end
      end
   end

   assign o_cmd_ready = cmd_ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_busy      = busy_q;
   assign o_psel      = psel_q;
   assign o_penable   = penable_q;
   assign o_pwrite    = pwrite_q;
   assign o_paddr     = paddr_q;
   assign o_pwdata    = pwdata_q;

endmodule

// File: doc/apb_csr_master.md
Name: apb_csr_master

Overview:
- APB requester for the CSR register block; the initiating end of the same APB link.
- Accepts single read/write commands on a valid/ready command port and runs each as one APB transfer: SETUP phase, then ACCESS phase.
- Returns read data and error status on a one-cycle response strobe.
- Used by bring-up logic and benches to program and read back the 8-entry, 8-bit CSR file without hand-toggling APB pins.

Parameters:
- ADDR_W, 3: width of command address and PADDR (8 registers).
- DATA_W, 8: width of write data, read data, PWDATA and PRDATA.
- TIMEOUT_CYC, 16: maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command request.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_W  register address.
- i_cmd_wdata  in  DATA_W  write data; ignored for reads.
- o_cmd_ready  out  1  command accepted when valid & ready.
- o_rsp_valid  out  1  one-cycle completion strobe.
- o_rsp_rdata  out  DATA_W  read data; 0 for writes and aborts.
- o_rsp_err  out  1  PSLVERR was seen, or the timeout fired.
- o_busy  out  1  transfer in progress (SETUP or ACCESS).
- o_psel  out  1  APB PSEL.
- o_penable  out  1  APB PENABLE.
- o_pwrite  out  1  APB PWRITE.
- o_paddr  out  ADDR_W  APB PADDR.
- o_pwdata  out  DATA_W  APB PWDATA.
- i_prdata  in  DATA_W  APB PRDATA.
- i_pready  in  1  APB PREADY.
- i_pslverr  in  1  APB PSLVERR.

Behaviour:
- Interface: one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset values: every output 0, wait counter 0, FSM in IDLE. Assertion clears state immediately, without waiting for a clock edge.
- o_cmd_ready is 0 while i_rst is high, and 1 in IDLE once reset is released.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - o_cmd_ready = 1; o_psel = o_penable = 0.
  - On valid & ready: capture write/addr/wdata into o_pwrite/o_paddr/o_pwdata and go to SETUP.
  - Command inputs are ignored after capture.
- SETUP (exactly 1 cycle):
  - o_psel = 1, o_penable = 0, o_cmd_ready = 0, o_busy = 1.
  - Next state is ACCESS, unconditionally.
- ACCESS:
  - o_psel = 1, o_penable = 1; PADDR/PWRITE/PWDATA held stable.
  - If i_pready is sampled 1 at a rising edge:
    - The next cycle is IDLE with psel = penable = 0 and o_rsp_valid = 1.
    - o_rsp_err = i_pslverr.
    - o_rsp_rdata = i_prdata if read, else 0.
  - If i_pready is 0: increment the wait counter.
  - When TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC: abort to IDLE with o_rsp_valid = 1, o_rsp_err = 1, o_rsp_rdata = 0.
  - The wait counter clears on entry to SETUP.
- i_pslverr and i_prdata are sampled only in ACCESS with i_pready = 1; ignored at all other times.
- Response timing:
  - o_rsp_valid is high for exactly one cycle: the first IDLE cycle after completion.
  - o_cmd_ready is also 1 in that cycle, so a new command may be accepted concurrently.
  - o_rsp_rdata and o_rsp_err hold their values until the next response.
- Latency and throughput:
  - Zero-wait-state slave: command accepted at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, response in cycle N+3.
  - Maximum throughput is one command per 3 cycles.
  - Each PREADY-low cycle adds one cycle.
- o_pwdata and o_paddr keep their last values in IDLE; they are not zeroed after a transfer.
- Reset mid-transfer:
  - psel/penable drop asynchronously.
  - No o_rsp_valid is produced for the aborted command.
- PREADY behaviour:
  - PREADY high during SETUP has no effect; ACCESS always lasts at least 1 cycle.
  - PREADY in IDLE is ignored.
- No response back-pressure: the consumer must take o_rsp_valid in the cycle it is asserted.

Test Plan:
- Write, zero-wait: cmd write addr=3'b010 wdata=8'd100, pready tied 1.
  -> psel high 2 cycles, penable high 1 cycle, paddr=2, pwdata=100, pwrite=1.
  -> rsp_valid 3 cycles after accept, err=0, rdata=0.
- Read, 2 wait states: cmd read addr=3'b010, slave holds pready=0 for 2 ACCESS cycles, then drives prdata=8'd100, pready=1.
  -> rsp_valid 5 cycles after accept, rdata=100, err=0.
- Slave error: write addr=3'b111, pready=1, pslverr=1.
  -> rsp_err=1; next command accepted in the same cycle as rsp_valid.
- Timeout, TIMEOUT_CYC=4: read with pready held 0.
  -> after 4 ACCESS cycles, psel/penable drop, rsp_valid=1, err=1, rdata=0.
- Back-to-back: 8 writes addr 0..7 with data addr*3, i_cmd_valid held high, then 8 reads.
  -> one accept every 3 cycles; readback 0,3,...,21 in order.
- Async reset in ACCESS: assert i_rst mid-cycle with pready=0.
  -> psel/penable 0 before the next edge, no rsp_valid, o_cmd_ready=1 after release.
